mem_port_scheduler: RTL and testbench
=====================================

// Module: mem_port_scheduler
// PURPOSE
//  Shares a single memory request port between NUM_OF_CORES vector cores. Picks an owner per burst using
//  round-robin with a registered one-hot grant, locks the port until the burst's last beat, tracks read
//  ownership in an in-order ID FIFO, and routes each read response back to the core that issued it.
//  Sits between the core load/store units and the shared memory controller.
// PARAMETERS
//  NUM_OF_CORES  4   number of requesting cores; ID_W = $clog2(NUM_OF_CORES)
//  ADDR_W        32  request address width
//  DATA_W        64  write/read data width
//  OUTSTANDING   4   max in-flight reads; depth of the ID FIFO; must be >= 1
// PORTS
//  clk            in   1                clock
//  reset          in   1                asynchronous, active-low reset
//  core_req_valid in   NUM_OF_CORES     per-core request valid
//  core_req_ready out  NUM_OF_CORES     per-core request accepted (at most one bit set)
//  core_req_we    in   NUM_OF_CORES     1 = write, 0 = read
//  core_req_last  in   NUM_OF_CORES     last beat of the burst; releases the lock
//  core_req_addr  in   NUM_OF_CORES*ADDR_W  packed, core i at [i*ADDR_W +: ADDR_W]
//  core_req_wdata in   NUM_OF_CORES*DATA_W  packed, core i at [i*DATA_W +: DATA_W]
//  grant          out  NUM_OF_CORES     registered one-hot current owner; all zeros when idle
//  mem_req_valid  out  1                request to memory
//  mem_req_ready  in   1                memory accepts request
//  mem_req_we / mem_req_addr / mem_req_wdata  out  1/ADDR_W/DATA_W  owner's fields, muxed
//  mem_rsp_valid  in   1                in-order read data valid (no backpressure)
//  mem_rsp_rdata  in   DATA_W           read data
//  core_rsp_valid out  NUM_OF_CORES     registered one-hot response strobe
//  core_rsp_rdata out  DATA_W           registered read data, shared by all cores
//  err_orphan_rsp out  1                sticky: response arrived while the ID FIFO was empty
// BEHAVIOUR
//  Reset: grant=0, core_req_ready=0, mem_req_valid=0, core_rsp_valid=0, core_rsp_rdata=0, err_orphan_rsp=0.
//    Also clears FSM=IDLE, rr pointer=0 (core 0 highest priority) and ID FIFO to empty.
//    A reset mid-burst or with reads in flight discards all state; late memory responses after reset set err_orphan_rsp.
//  FSM IDLE: grant=0, no ready.
//    If any core_req_valid is set, pick the first requester at or after the rr pointer, cyclically.
//    Register its one-hot grant and go to BUSY. Arbitration latency is 1 cycle.
//  FSM BUSY: mem_req_valid = core_req_valid[owner]; mem_req_* = owner's fields.
//    core_req_ready[owner] = mem_req_ready & (we | !fifo_full). All other ready bits are 0.
//    When a read is blocked by a full FIFO, mem_req_valid=0.
//    Beat accepted (valid & ready) with last=1: go to IDLE, rr pointer = owner+1 (mod NUM_OF_CORES), grant=0 next cycle.
//    Owner dropping valid mid-burst keeps the lock: stay in BUSY, mem_req_valid=0.
//    Other requesters wait; their pending requests do not change the owner.
//    A single-beat burst is last=1 on the first beat. The minimum per-burst cost is 1 arb cycle + 1 beat.
//  ID FIFO: an accepted read pushes the owner ID; mem_rsp_valid pops. Writes do not push.
//    full = count==OUTSTANDING. Push is gated on !full with no same-cycle pop bypass. Pointers wrap mod OUTSTANDING.
//    Simultaneous push and pop: count unchanged.
//  Response path: the cycle after mem_rsp_valid, core_rsp_valid = onehot(popped ID) and core_rsp_rdata = mem_rsp_rdata.
//    core_rsp_valid is 0 otherwise; core_rsp_rdata holds its value.
//  mem_rsp_valid with the FIFO empty: no pop, no core strobe, err_orphan_rsp <= 1 (cleared only by reset).
// TESTING
//  T1 reset: drive all valids=1 during reset -> grant=0, ready=0, mem_req_valid=0, err=0; core0 granted 1 cycle after release.
//  T2 fairness: cores 0-3 hold single-beat reads (last=1), mem ready=1, rsp returned each cycle
//     -> grants cycle 0,1,2,3,0; each core gets one beat per 2-cycle slot.
//  T3 burst lock: core1 issues a 4-beat write (last on beat 4) while core2 requests
//     -> grant stays 0010 for 4 beats even with a 1-cycle valid gap; then grant 0100.
//  T4 credits: OUTSTANDING=4, core0 issues 6 single-beat reads and mem holds responses
//     -> 4 accepted, ready=0 after; one response pops and the 5th is accepted the next cycle.
//  T5 routing: core3 read then core1 read, responses D0/D1
//     -> core_rsp_valid=1000 with D0, then 0010 with D1, each 1 cycle after mem_rsp_valid.
//  T6 orphan + mid-op reset: mem_rsp_valid with FIFO empty -> err_orphan_rsp=1 sticky.
//     Assert reset mid-burst -> all outputs return to reset values and the FIFO is empty.

Source files
------------

// File: rtl/mem_port_scheduler.sv
// Round-robin owner per burst on a shared memory request port; reads tracked in an in-order ID FIFO
// so each response is steered back to its issuing core one cycle after it arrives.
module mem_port_scheduler #(
  parameter int NUM_OF_CORES = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 64,
  parameter int OUTSTANDING  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_OF_CORES-1:0]          core_req_valid,
  output logic [NUM_OF_CORES-1:0]          core_req_ready,
  input  logic [NUM_OF_CORES-1:0]          core_req_we,
  input  logic [NUM_OF_CORES-1:0]          core_req_last,
  input  logic [NUM_OF_CORES*ADDR_W-1:0]   core_req_addr,
  input  logic [NUM_OF_CORES*DATA_W-1:0]   core_req_wdata,
  output logic [NUM_OF_CORES-1:0]          grant,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_we,
  output logic [ADDR_W-1:0]                mem_req_addr,
  output logic [DATA_W-1:0]                mem_req_wdata,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_W-1:0]                mem_rsp_rdata,
  output logic [NUM_OF_CORES-1:0]          core_rsp_valid,
  output logic [DATA_W-1:0]                core_rsp_rdata,
  output logic                             err_orphan_rsp
);

  localparam int ID_W  = (NUM_OF_CORES > 1) ? $clog2(NUM_OF_CORES) : 1;
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam logic [NUM_OF_CORES-1:0] ONE = NUM_OF_CORES'(1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e                   state_q;
  logic [NUM_OF_CORES-1:0]  grant_q;
  logic [ID_W-1:0]          owner_q;
  logic [ID_W-1:0]          rr_q;

  logic [ID_W-1:0]          fifo_q [OUTSTANDING];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [NUM_OF_CORES-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]        rsp_rdata_q;
  logic                     err_q;

  logic                     pick_vld;
  logic [ID_W-1:0]          pick_id;
  logic                     busy, own_vld, own_we, own_last;
  logic                     fifo_full, fifo_empty;
  logic                     own_rdy, accept, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // First requester at or after the rr pointer, scanning cyclically.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    idx      = 0;
    cand     = '0;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 0; k < NUM_OF_CORES; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_OF_CORES) idx = idx - NUM_OF_CORES;
      cand = ID_W'(idx);
      if (!pick_vld && core_req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  assign busy       = (state_q == S_BUSY);
  assign own_vld    = core_req_valid[owner_q];
  assign own_we     = core_req_we[owner_q];
  assign own_last   = core_req_last[owner_q];
  assign fifo_full  = (cnt_q == CNT_W'(OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);

  // A read is held off entirely while every response credit is in flight.
  assign own_rdy       = busy & mem_req_ready & (own_we | ~fifo_full);
  assign mem_req_valid = busy & own_vld & (own_we | ~fifo_full);
  assign accept        = mem_req_valid & mem_req_ready;
  assign push          = accept & ~own_we;
  assign pop           = mem_rsp_valid & ~fifo_empty;

  always_comb begin
    core_req_ready          = '0;
    core_req_ready[owner_q] = own_rdy;
  end

  assign mem_req_we    = own_we;
  assign mem_req_addr  = core_req_addr[int'(owner_q)*ADDR_W +: ADDR_W];
  assign mem_req_wdata = core_req_wdata[int'(owner_q)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            state_q <= S_BUSY;
            owner_q <= pick_id;
            grant_q <= ONE << pick_id;
          end
        end
        S_BUSY: begin
          // Lock holds through valid gaps; only an accepted last beat releases it.
          if (accept && own_last) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= (owner_q == ID_W'(NUM_OF_CORES - 1)) ? '0 : owner_q + ID_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= owner_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rsp_valid_d = pop ? (ONE << fifo_q[rd_ptr_q]) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (pop) rsp_rdata_q <= mem_rsp_rdata;
      if (mem_rsp_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign grant          = grant_q;
  assign core_rsp_valid = rsp_valid_q;
  assign core_rsp_rdata = rsp_rdata_q;
  assign err_orphan_rsp = err_q;

  a_grant_onehot : assert property (@(posedge clk) disable iff (!reset) $onehot0(grant_q));
  a_ready_onehot : assert property (@(posedge clk) disable iff (!reset) $onehot0(core_req_ready));
  a_cnt_bound    : assert property (@(posedge clk) disable iff (!reset) cnt_q <= CNT_W'(OUTSTANDING));

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler: vector table for round-robin fairness, hand sequences for lock/credit/routing/reset.
module tb_mem_port_scheduler;

  logic         clk;
  logic         reset;
  logic [3:0]   core_req_valid, core_req_ready, core_req_we, core_req_last;
  logic [127:0] core_req_addr;
  logic [255:0] core_req_wdata;
  logic [3:0]   grant;
  logic         mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [63:0]  mem_req_wdata;
  logic         mem_rsp_valid;
  logic [63:0]  mem_rsp_rdata;
  logic [3:0]   core_rsp_valid;
  logic [63:0]  core_rsp_rdata;
  logic         err_orphan_rsp;

  mem_port_scheduler dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_we(core_req_we), .core_req_last(core_req_last),
    .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
    .grant(grant),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
    .err_orphan_rsp(err_orphan_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  vld, we, last;
    logic        mrdy, rvld;
    logic [63:0] rdat;
    logic [7:0]  tag;
    logic [3:0]  e_gnt, e_rdy;
    logic        e_mvld;
    logic [3:0]  e_rsp;
    logic [63:0] e_rdat;
    logic        e_err;
  } vec_t;

  localparam logic [63:0] DA = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] DB = 64'hBBBB_0000_0000_0002;
  localparam logic [63:0] DC = 64'hCCCC_0000_0000_0003;
  localparam logic [63:0] DD = 64'hDDDD_0000_0000_0004;
  localparam logic [63:0] DE = 64'hEEEE_0000_0000_0005;
  localparam logic [63:0] DF = 64'hF0F0_0000_0000_0006;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] DG = 64'h5555_0000_0000_0007;
  localparam logic [63:0] DH = 64'h6666_0000_0000_0008;
  localparam logic [63:0] Z  = 64'h0;

  int total = 0;
  int bad   = 0;
  int tid   = 0;
  int sid   = 0;

  function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] we, input logic [3:0] last,
                              input logic mrdy, input logic rvld, input logic [63:0] rdat,
                              input logic [7:0] tag, input logic [3:0] e_gnt, input logic [3:0] e_rdy,
                              input logic e_mvld, input logic [3:0] e_rsp, input logic [63:0] e_rdat,
                              input logic e_err);
    vec_t v;
    v.vld = vld; v.we = we; v.last = last; v.mrdy = mrdy; v.rvld = rvld; v.rdat = rdat;
    v.tag = tag; v.e_gnt = e_gnt; v.e_rdy = e_rdy; v.e_mvld = e_mvld; v.e_rsp = e_rsp;
    v.e_rdat = e_rdat; v.e_err = e_err;
    return v;
  endfunction

  function automatic int oh2idx(input logic [3:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL t%0d step%0d %s: got %h want %h", tid, sid, nm, act, exp);
    end
  endtask

  // Called just after a negedge: drive, let logic settle, compare, advance one cycle.
  task automatic step(input vec_t v);
    int o;
    core_req_valid = v.vld;
    core_req_we    = v.we;
    core_req_last  = v.last;
    mem_req_ready  = v.mrdy;
    mem_rsp_valid  = v.rvld;
    mem_rsp_rdata  = v.rdat;
    for (int i = 0; i < 4; i++) begin
      core_req_addr[i*32 +: 32]  = {16'hA000, 8'(i), v.tag};
      core_req_wdata[i*64 +: 64] = {16'hD000, 8'h00, 8'(i), 24'h0, v.tag};
    end
    #1;
    chk("grant", 64'(grant), 64'(v.e_gnt));
    chk("req_ready", 64'(core_req_ready), 64'(v.e_rdy));
    chk("mem_req_valid", 64'(mem_req_valid), 64'(v.e_mvld));
    chk("core_rsp_valid", 64'(core_rsp_valid), 64'(v.e_rsp));
    chk("err_orphan", 64'(err_orphan_rsp), 64'(v.e_err));
    if (v.e_rsp != 4'b0) chk("core_rsp_rdata", core_rsp_rdata, v.e_rdat);
    if (v.e_mvld) begin
      o = oh2idx(v.e_gnt);
      chk("mem_req_addr", 64'(mem_req_addr), 64'({16'hA000, 8'(o), v.tag}));
      chk("mem_req_we", 64'(mem_req_we), 64'(v.we[o]));
      chk("mem_req_wdata", mem_req_wdata, {16'hD000, 8'h00, 8'(o), 24'h0, v.tag});
    end
    sid++;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] vld);
    reset          = 1'b0;
    core_req_valid = vld;
    core_req_we    = 4'b0;
    core_req_last  = 4'hF;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_rdata  = 64'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant", 64'(grant), Z);
    chk("rst_ready", 64'(core_req_ready), Z);
    chk("rst_mem_valid", 64'(mem_req_valid), Z);
    chk("rst_rsp_valid", 64'(core_rsp_valid), Z);
    chk("rst_rsp_rdata", core_rsp_rdata, Z);
    chk("rst_err", 64'(err_orphan_rsp), Z);
    reset = 1'b1;
    sid   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t2 [12];
    t2[0]  = mk(4'hF, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0000, Z,  1'b0);
    t2[1]  = mk(4'hF, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd1, 4'b0001, 4'b0001, 1'b1, 4'b0000, Z,  1'b0);
    t2[2]  = mk(4'hF, 4'h0, 4'hF, 1'b1, 1'b1, DA, 8'd2, 4'b0000, 4'b0000, 1'b0, 4'b0000, Z,  1'b0);
    t2[3]  = mk(4'hF, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd3, 4'b0010, 4'b0010, 1'b1, 4'b0001, DA, 1'b0);
    t2[4]  = mk(4'hF, 4'h0, 4'hF, 1'b1, 1'b1, DB, 8'd4, 4'b0000, 4'b0000, 1'b0, 4'b0000, Z,  1'b0);
    t2[5]  = mk(4'hF, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd5, 4'b0100, 4'b0100, 1'b1, 4'b0010, DB, 1'b0);
    t2[6]  = mk(4'hF, 4'h0, 4'hF, 1'b1, 1'b1, DC, 8'd6, 4'b0000, 4'b0000, 1'b0, 4'b0000, Z,  1'b0);
    t2[7]  = mk(4'hF, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd7, 4'b1000, 4'b1000, 1'b1, 4'b0100, DC, 1'b0);
    t2[8]  = mk(4'hF, 4'h0, 4'hF, 1'b1, 1'b1, DD, 8'd8, 4'b0000, 4'b0000, 1'b0, 4'b0000, Z,  1'b0);
    t2[9]  = mk(4'hF, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd9, 4'b0001, 4'b0001, 1'b1, 4'b1000, DD, 1'b0);
    t2[10] = mk(4'h0, 4'h0, 4'hF, 1'b1, 1'b1, DE, 8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0000, Z,  1'b0);
    t2[11] = mk(4'h0, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0001, DE, 1'b0);

    reset = 1'b0;
    core_req_valid = 4'h0; core_req_we = 4'h0; core_req_last = 4'h0;
    core_req_addr = '0; core_req_wdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;

    // T1: requests held during reset, core 0 wins the first arbitration
    tid = 1;
    do_reset(4'hF);
    step(mk(4'hF, 4'h0, 4'hF, 1'b1, 1'b0, Z, 8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0000, Z, 1'b0));
    step(mk(4'hF, 4'h0, 4'hF, 1'b1, 1'b0, Z, 8'd0, 4'b0001, 4'b0001, 1'b1, 4'b0000, Z, 1'b0));

    // T2: round-robin over four single-beat readers
    tid = 2;
    do_reset(4'h0);
    for (int i = 0; i < 12; i++) step(t2[i]);

    // T3: core1 write burst with a valid gap keeps the lock against core2
    tid = 3;
    do_reset(4'h0);
    step(mk(4'b0110, 4'b0110, 4'b0000, 1'b1, 1'b0, Z, 8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0, Z, 1'b0));
    step(mk(4'b0110, 4'b0110, 4'b0000, 1'b1, 1'b0, Z, 8'd1, 4'b0010, 4'b0010, 1'b1, 4'b0, Z, 1'b0));
    step(mk(4'b0110, 4'b0110, 4'b0000, 1'b1, 1'b0, Z, 8'd2, 4'b0010, 4'b0010, 1'b1, 4'b0, Z, 1'b0));
    step(mk(4'b0100, 4'b0110, 4'b0000, 1'b1, 1'b0, Z, 8'd2, 4'b0010, 4'b0010, 1'b0, 4'b0, Z, 1'b0));
    step(mk(4'b0110, 4'b0110, 4'b0000, 1'b1, 1'b0, Z, 8'd3, 4'b0010, 4'b0010, 1'b1, 4'b0, Z, 1'b0));
    step(mk(4'b0110, 4'b0110, 4'b0010, 1'b1, 1'b0, Z, 8'd4, 4'b0010, 4'b0010, 1'b1, 4'b0, Z, 1'b0));
    step(mk(4'b0100, 4'b0110, 4'b0100, 1'b1, 1'b0, Z, 8'd4, 4'b0000, 4'b0000, 1'b0, 4'b0, Z, 1'b0));
    step(mk(4'b0100, 4'b0110, 4'b0100, 1'b1, 1'b0, Z, 8'd5, 4'b0100, 4'b0100, 1'b1, 4'b0, Z, 1'b0));
    step(mk(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, Z, 8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0, Z, 1'b0));

    // T4: read credits run out after four, one response frees one
    tid = 4;
    do_reset(4'h0);
    for (int i = 0; i < 4; i++) begin
      step(mk(4'b0001, 4'h0, 4'hF, 1'b1, 1'b0, Z, 8'(i), 4'b0000, 4'b0000, 1'b0, 4'b0, Z, 1'b0));
      step(mk(4'b0001, 4'h0, 4'hF, 1'b1, 1'b0, Z, 8'(i), 4'b0001, 4'b0001, 1'b1, 4'b0, Z, 1'b0));
    end
    step(mk(4'b0001, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd4, 4'b0000, 4'b0000, 1'b0, 4'b0000, Z,  1'b0));
    step(mk(4'b0001, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd4, 4'b0001, 4'b0000, 1'b0, 4'b0000, Z,  1'b0));
    step(mk(4'b0001, 4'h0, 4'hF, 1'b1, 1'b1, DF, 8'd4, 4'b0001, 4'b0000, 1'b0, 4'b0000, Z,  1'b0));
    step(mk(4'b0001, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd4, 4'b0001, 4'b0001, 1'b1, 4'b0001, DF, 1'b0));
    step(mk(4'b0001, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd5, 4'b0000, 4'b0000, 1'b0, 4'b0000, Z,  1'b0));
    step(mk(4'b0001, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd5, 4'b0001, 4'b0000, 1'b0, 4'b0000, Z,  1'b0));

    // T5: responses routed back to core3 then core1, data held afterwards
    tid = 5;
    do_reset(4'h0);
    step(mk(4'b1000, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0000, Z,  1'b0));
    step(mk(4'b1000, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd3, 4'b1000, 4'b1000, 1'b1, 4'b0000, Z,  1'b0));
    step(mk(4'b0010, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0000, Z,  1'b0));
    step(mk(4'b0010, 4'h0, 4'hF, 1'b1, 1'b1, D0, 8'd1, 4'b0010, 4'b0010, 1'b1, 4'b0000, Z,  1'b0));
    step(mk(4'b0000, 4'h0, 4'hF, 1'b1, 1'b1, D1, 8'd0, 4'b0000, 4'b0000, 1'b0, 4'b1000, D0, 1'b0));
    step(mk(4'b0000, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0010, D1, 1'b0));
    step(mk(4'b0000, 4'h0, 4'hF, 1'b1, 1'b0, Z,  8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0000, Z,  1'b0));
    chk("rdata_hold", core_rsp_rdata, D1);

    // T6: orphan response is sticky; reset mid-burst with a read in flight clears everything
    tid = 6;
    do_reset(4'h0);
    step(mk(4'b0000, 4'h0,    4'hF,    1'b1, 1'b1, DG, 8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0, Z, 1'b0));
    step(mk(4'b0000, 4'h0,    4'hF,    1'b1, 1'b0, Z,  8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0, Z, 1'b1));
    step(mk(4'b0001, 4'h0,    4'hF,    1'b1, 1'b0, Z,  8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0, Z, 1'b1));
    step(mk(4'b0001, 4'h0,    4'hF,    1'b1, 1'b0, Z,  8'd7, 4'b0001, 4'b0001, 1'b1, 4'b0, Z, 1'b1));
    step(mk(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, Z,  8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0, Z, 1'b1));
    step(mk(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, Z,  8'd9, 4'b0100, 4'b0100, 1'b1, 4'b0, Z, 1'b1));
    do_reset(4'b0100);
    step(mk(4'b0000, 4'h0,    4'hF,    1'b1, 1'b1, DH, 8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0, Z, 1'b0));
    step(mk(4'b0000, 4'h0,    4'hF,    1'b1, 1'b0, Z,  8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0, Z, 1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
